// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the pipeline hazard controller.
//   fwd_sel_t  - ALU operand forwarding select (register file / writeback / memory)
//   state_t    - mul/div wait FSM states
//   REG_ZERO   - architectural zero register, which never creates a hazard
//   fwd_select - priority encoder turning M/W match flags into a forward select
package core_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN,
        ST_MDWAIT
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // The M stage holds the younger result, so it wins over W.
    function automatic fwd_sel_t fwd_select(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end else if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the pipeline datapath and hazard_ctrl.
//   master - pipeline side: drives register tags, enables and mul/div handshake,
//            receives forward selects, stall/flush controls and status.
//   slave  - hazard controller side (the mirror of master).
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       RsD;
    logic [4:0]       RtD;
    logic             BranchD;
    logic [4:0]       RsE;
    logic [4:0]       RtE;
    logic [4:0]       WriteRegE;
    logic [4:0]       WriteRegM;
    logic [4:0]       WriteRegW;
    logic             RegWriteE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             MemtoRegM;
    logic             muldivStartE;
    logic             muldivDone;

    logic             ForwardAD;
    logic             ForwardBD;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushE;
    logic             hazardDetected;
    logic             muldivTimeout;
    logic [CNT_W-1:0] stallCycles;

    modport master (
        output RsD, RtD, BranchD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               muldivStartE, muldivDone,
        input  ForwardAD, ForwardBD, ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushE, hazardDetected, muldivTimeout, stallCycles
    );

    modport slave (
        input  RsD, RtD, BranchD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               muldivStartE, muldivDone,
        output ForwardAD, ForwardBD, ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushE, hazardDetected, muldivTimeout, stallCycles
    );

endinterface

// File: rtl/hazard_match.sv
// hazard_match: combinational register-tag comparator.
//   src   - consuming instruction's source register
//   dst   - producing instruction's destination register
//   we    - qualifier for the producer (write enable or load flag)
//   match - high when the producer really feeds the consumer; $0 never matches
module hazard_match
    import core_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] dst,
    input  logic       we,
    output logic       match
);

    assign match = we && (src != REG_ZERO) && (src == dst);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection, forwarding and stall control for the 5-stage core.
//   clk   - rising-edge clock
//   reset - synchronous, active-high; forces a flush and clears all state
//   hz    - hazard_ctrl_if.slave: D/E/M/W register tags and enables, mul/div
//           handshake in; forward selects, StallF/D/E, FlushE, hazardDetected,
//           sticky muldivTimeout and saturating stallCycles out.
// Stall/flush/forward outputs are combinational (same-cycle); only the FSM
// state, wait counter, timeout flag and stall counter are registered.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MULDIV_MAX = 64,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    localparam int WAIT_W = $clog2(MULDIV_MAX + 1);
    // Last wait-counter value before the counter would reach MULDIV_MAX-1;
    // together with the start cycle this bounds a wait at MULDIV_MAX stalls.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MULDIV_MAX - 2);

    // ---------------------------------------------------------------
    // Register comparisons
    // ---------------------------------------------------------------
    logic rs_e_m, rs_e_w, rt_e_m, rt_e_w;   // E-stage operand forwarding
    logic rs_d_m, rt_d_m;                   // D-stage branch forwarding
    logic rs_d_ld, rt_d_ld;                 // load in E feeds D
    logic rs_d_we, rt_d_we;                 // ALU result in E feeds branch in D
    logic rs_d_lm, rt_d_lm;                 // load in M feeds branch in D

    hazard_match u_rs_e_m  (.src(hz.RsE), .dst(hz.WriteRegM), .we(hz.RegWriteM), .match(rs_e_m));
    hazard_match u_rs_e_w  (.src(hz.RsE), .dst(hz.WriteRegW), .we(hz.RegWriteW), .match(rs_e_w));
    hazard_match u_rt_e_m  (.src(hz.RtE), .dst(hz.WriteRegM), .we(hz.RegWriteM), .match(rt_e_m));
    hazard_match u_rt_e_w  (.src(hz.RtE), .dst(hz.WriteRegW), .we(hz.RegWriteW), .match(rt_e_w));
    hazard_match u_rs_d_m  (.src(hz.RsD), .dst(hz.WriteRegM), .we(hz.RegWriteM), .match(rs_d_m));
    hazard_match u_rt_d_m  (.src(hz.RtD), .dst(hz.WriteRegM), .we(hz.RegWriteM), .match(rt_d_m));
    hazard_match u_rs_d_ld (.src(hz.RsD), .dst(hz.WriteRegE), .we(hz.MemtoRegE), .match(rs_d_ld));
    hazard_match u_rt_d_ld (.src(hz.RtD), .dst(hz.WriteRegE), .we(hz.MemtoRegE), .match(rt_d_ld));
    hazard_match u_rs_d_we (.src(hz.RsD), .dst(hz.WriteRegE), .we(hz.RegWriteE), .match(rs_d_we));
    hazard_match u_rt_d_we (.src(hz.RtD), .dst(hz.WriteRegE), .we(hz.RegWriteE), .match(rt_d_we));
    hazard_match u_rs_d_lm (.src(hz.RsD), .dst(hz.WriteRegM), .we(hz.MemtoRegM), .match(rs_d_lm));
    hazard_match u_rt_d_lm (.src(hz.RtD), .dst(hz.WriteRegM), .we(hz.MemtoRegM), .match(rt_d_lm));

    logic lwstall;
    logic branchstall;

    assign lwstall     = rs_d_ld | rt_d_ld;
    assign branchstall = hz.BranchD & (rs_d_we | rt_d_we | rs_d_lm | rt_d_lm);

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t           state;
    logic [WAIT_W-1:0] wait_cnt;
    logic             timeout_flag;
    logic [CNT_W-1:0] stall_cnt;

    // ---------------------------------------------------------------
    // Combinational stall / flush / forward outputs
    // ---------------------------------------------------------------
    logic     stall_f;
    logic     stall_e;
    logic     flush_e;
    fwd_sel_t fwd_a_e;
    fwd_sel_t fwd_b_e;
    logic     fwd_a_d;
    logic     fwd_b_d;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        stall_f = 1'b0;
        stall_e = 1'b0;
        flush_e = 1'b0;
        fwd_a_e = FWD_RF;
        fwd_b_e = FWD_RF;
        fwd_a_d = 1'b0;
        fwd_b_d = 1'b0;

        if (reset) begin
            // The register being reset must not hold, and E is cleared.
            flush_e = 1'b1;
        end else begin
            fwd_a_e = fwd_select(rs_e_m, rs_e_w);
            fwd_b_e = fwd_select(rt_e_m, rt_e_w);
            fwd_a_d = rs_d_m;
            fwd_b_d = rt_d_m;

            if (state == ST_MDWAIT || hz.muldivStartE) begin
                // Freeze F/D/E while mul/div runs; a flush would destroy the
                // instruction waiting for its result.
                stall_f = 1'b1;
                stall_e = 1'b1;
            end else begin
                stall_f = lwstall | branchstall;
                flush_e = lwstall | branchstall;
            end
        end
    end

    assign hz.StallF         = stall_f;
    assign hz.StallD         = stall_f;
    assign hz.hazardDetected = stall_f;
    assign hz.StallE         = stall_e;
    assign hz.FlushE         = flush_e;
    assign hz.ForwardAE      = fwd_a_e;
    assign hz.ForwardBE      = fwd_b_e;
    assign hz.ForwardAD      = fwd_a_d;
    assign hz.ForwardBD      = fwd_b_d;
    assign hz.muldivTimeout  = timeout_flag;
    assign hz.stallCycles    = stall_cnt;

    // ---------------------------------------------------------------
    // FSM, watchdog and performance counter
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments and a synchronous
        // reset that takes priority over every other update.
        if (reset) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            if (stall_f && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            case (state)
                ST_RUN: begin
                    // Start with done in the same cycle completes immediately;
                    // a stray done with no start is ignored.
                    if (hz.muldivStartE && !hz.muldivDone) begin
                        state    <= ST_MDWAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MDWAIT: begin
                    // Done wins over a watchdog expiry in the same cycle.
                    if (hz.muldivDone) begin
                        state <= ST_RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state        <= ST_RUN;
                        timeout_flag <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios followed by randomized traffic, every cycle
// compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int MD_MAX = 8;
    localparam int CW     = 8;
    localparam int SAT    = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hz ();

    hazard_ctrl #(.MULDIV_MAX(MD_MAX), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: an outstanding mul/div and how many stall cycles it has used.
    bit m_busy    = 1'b0;
    int m_len     = 0;
    bit m_timeout = 1'b0;
    int m_stalls  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (src != 0 && hz.RegWriteM && src == hz.WriteRegM) return 2'b10;
        if (src != 0 && hz.RegWriteW && src == hz.WriteRegW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit uses(input logic [4:0] dst);
        return dst != 0 && (dst == hz.RsD || dst == hz.RtD);
    endfunction

    task automatic idle();
        hz.RsD = 0; hz.RtD = 0; hz.BranchD = 0; hz.RsE = 0; hz.RtE = 0;
        hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
        hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
        hz.MemtoRegE = 0; hz.MemtoRegM = 0;
        hz.muldivStartE = 0; hz.muldivDone = 0;
    endtask

    // Checks the current cycle against the model, then advances the model across
    // the next clock edge. Inputs are driven 1 time unit after posedge.
    task automatic do_cycle();
        bit e_stall, e_stall_e, e_flush, hzd;
        #4;
        hzd = (hz.MemtoRegE && uses(hz.WriteRegE)) ||
              (hz.BranchD && ((hz.RegWriteE && uses(hz.WriteRegE)) ||
                              (hz.MemtoRegM && uses(hz.WriteRegM))));
        if (reset) begin
            e_stall = 0; e_stall_e = 0; e_flush = 1;
        end else if (m_busy || hz.muldivStartE) begin
            e_stall = 1; e_stall_e = 1; e_flush = 0;
        end else begin
            e_stall = hzd; e_stall_e = 0; e_flush = hzd;
        end
        check("StallF", hz.StallF, e_stall);
        check("StallD", hz.StallD, e_stall);
        check("hazardDetected", hz.hazardDetected, e_stall);
        check("StallE", hz.StallE, e_stall_e);
        check("FlushE", hz.FlushE, e_flush);
        check("ForwardAE", hz.ForwardAE, reset ? 2'b00 : exp_fwd(hz.RsE));
        check("ForwardBE", hz.ForwardBE, reset ? 2'b00 : exp_fwd(hz.RtE));
        if (!reset) begin
            check("ForwardAD", hz.ForwardAD, hz.RsD != 0 && hz.RegWriteM && hz.RsD == hz.WriteRegM);
            check("ForwardBD", hz.ForwardBD, hz.RtD != 0 && hz.RegWriteM && hz.RtD == hz.WriteRegM);
        end
        check("muldivTimeout", hz.muldivTimeout, m_timeout);
        check("stallCycles", hz.stallCycles, m_stalls);

        if (reset) begin
            m_busy = 0; m_len = 0; m_timeout = 0; m_stalls = 0;
        end else begin
            if (e_stall && m_stalls < SAT) m_stalls++;
            if (m_busy) begin
                m_len++;
                if (hz.muldivDone) begin
                    m_busy = 0;
                end else if (m_len == MD_MAX) begin
                    m_busy = 0;
                    m_timeout = 1;
                end
            end else if (hz.muldivStartE && !hz.muldivDone) begin
                m_busy = 1;
                m_len = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clk);
        #1;
        do_cycle();                       // reset cycle: flush, no stall
        reset = 0;
        #2 check("reset_stallCycles", hz.stallCycles, 0);
        check("reset_timeout", hz.muldivTimeout, 0);

        // Forwarding priority and the zero register
        hz.RsE = 3; hz.WriteRegM = 3; hz.RegWriteM = 1; hz.WriteRegW = 3; hz.RegWriteW = 1;
        #2 check("fwd_mem", hz.ForwardAE, 2'b10);
        do_cycle();
        hz.RegWriteM = 0;
        #2 check("fwd_wb", hz.ForwardAE, 2'b01);
        do_cycle();
        hz.RsE = 0; hz.RegWriteM = 1;
        #2 check("fwd_zero", hz.ForwardAE, 2'b00);
        do_cycle();

        // Load-use
        idle();
        hz.MemtoRegE = 1; hz.WriteRegE = 5; hz.RtD = 5;
        #2 check("lw_stall", hz.StallF, 1);
        check("lw_flush", hz.FlushE, 1);
        do_cycle();
        hz.WriteRegE = 0; hz.RtD = 0;
        #2 check("lw_count", hz.stallCycles, 1);
        check("lw_zero", hz.StallF, 0);
        do_cycle();

        // Branch on ALU result: stall in E, forward from M a cycle later
        idle();
        hz.BranchD = 1; hz.RsD = 7; hz.RegWriteE = 1; hz.WriteRegE = 7;
        #2 check("br_stall", hz.StallF, 1);
        check("br_flush", hz.FlushE, 1);
        do_cycle();
        hz.RegWriteE = 0; hz.WriteRegE = 0; hz.RegWriteM = 1; hz.WriteRegM = 7;
        #2 check("br_nostall", hz.StallF, 0);
        check("br_fwd", hz.ForwardAD, 1);
        do_cycle();

        // Mul/div with done 4 cycles after start
        idle();
        hz.muldivStartE = 1;
        #2 check("md_start_stallE", hz.StallE, 1);
        check("md_start_flush", hz.FlushE, 0);
        do_cycle();
        hz.muldivStartE = 0;
        for (int i = 0; i < 4; i++) begin
            hz.muldivDone = (i == 3);
            #2 check("md_wait_stallE", hz.StallE, 1);
            do_cycle();
        end
        hz.muldivDone = 0;
        #2 check("md_release", hz.StallE, 0);
        check("md_count", hz.stallCycles, 7);
        do_cycle();

        // Watchdog: no done ever arrives
        hz.muldivStartE = 1;
        do_cycle();
        hz.muldivStartE = 0;
        for (int i = 0; i < MD_MAX - 1; i++) begin
            #2 check("to_stall", hz.StallF, 1);
            do_cycle();
        end
        #2 check("to_release", hz.StallF, 0);
        check("to_flag", hz.muldivTimeout, 1);
        check("to_count", hz.stallCycles, 7 + MD_MAX);
        for (int i = 0; i < 3; i++) do_cycle();
        check("to_sticky", hz.muldivTimeout, 1);
        reset = 1;
        do_cycle();
        reset = 0;
        #2 check("to_cleared", hz.muldivTimeout, 0);

        // Reset during the third wait cycle
        hz.muldivStartE = 1;
        do_cycle();
        hz.muldivStartE = 0;
        do_cycle();
        do_cycle();
        reset = 1;
        #2 check("rst_wait_stall", hz.StallF, 0);
        check("rst_wait_flush", hz.FlushE, 1);
        do_cycle();
        reset = 0;
        #2 check("rst_wait_count", hz.stallCycles, 0);
        check("rst_wait_run", hz.StallF, 0);
        do_cycle();

        // Counter saturation under a long load-use stall
        hz.MemtoRegE = 1; hz.WriteRegE = 5; hz.RtD = 5;
        for (int i = 0; i < SAT + 40; i++) do_cycle();
        check("sat_count", hz.stallCycles, SAT);
        idle();
        do_cycle();

        // Randomized traffic over a small register range to provoke matches
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 63) == 0);
            hz.RsD          = 5'($urandom_range(0, 7));
            hz.RtD          = 5'($urandom_range(0, 7));
            hz.RsE          = 5'($urandom_range(0, 7));
            hz.RtE          = 5'($urandom_range(0, 7));
            hz.WriteRegE    = 5'($urandom_range(0, 7));
            hz.WriteRegM    = 5'($urandom_range(0, 7));
            hz.WriteRegW    = 5'($urandom_range(0, 7));
            hz.BranchD      = 1'($urandom_range(0, 1));
            hz.RegWriteE    = 1'($urandom_range(0, 1));
            hz.RegWriteM    = 1'($urandom_range(0, 1));
            hz.RegWriteW    = 1'($urandom_range(0, 1));
            hz.MemtoRegE    = ($urandom_range(0, 3) == 0);
            hz.MemtoRegM    = ($urandom_range(0, 3) == 0);
            hz.muldivStartE = ($urandom_range(0, 11) == 0);
            hz.muldivDone   = ($urandom_range(0, 9) == 0);
            do_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Sits beside instructionDecode. Compares the D-stage source registers (RsD, RtD) against destination registers in E, M and W.
- Drives the forwarding selects, stall and flush signals, and the hazardDetected flag that instructionDecode consumes.
- Owns a small FSM that holds the pipeline while the multi-cycle mul/div unit is busy, plus a timeout watchdog and a stall-cycle performance counter.

Parameters:
- MULDIV_MAX, 64, max cycles to wait for muldivDone before forcing an abort.
- CNT_W, 32, width of the stallCycles counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- RsD  in  5  D-stage source register A.
- RtD  in  5  D-stage source register B.
- BranchD  in  1  D-stage instruction is a branch (branch resolved in D via equalD).
- RsE  in  5  E-stage source register A.
- RtE  in  5  E-stage source register B.
- WriteRegE  in  5  E-stage destination register.
- WriteRegM  in  5  M-stage destination register.
- WriteRegW  in  5  W-stage destination register.
- RegWriteE  in  1  E-stage register-write enable.
- RegWriteM  in  1  M-stage register-write enable.
- RegWriteW  in  1  W-stage register-write enable.
- MemtoRegE  in  1  E-stage instruction is a load.
- MemtoRegM  in  1  M-stage instruction is a load.
- muldivStartE  in  1  E-stage issues a mul/div (1-cycle pulse).
- muldivDone  in  1  mul/div result ready.
- ForwardAD  out  1  D-stage branch comparator A takes ALUOutM.
- ForwardBD  out  1  D-stage branch comparator B takes ALUOutM.
- ForwardAE  out  2  E-stage ALU A select: 00 reg file, 01 ResultW, 10 ALUOutM.
- ForwardBE  out  2  E-stage ALU B select, same encoding as ForwardAE.
- StallF  out  1  hold the PC register.
- StallD  out  1  hold the IF/ID register.
- StallE  out  1  hold the ID/EX register.
- FlushE  out  1  clear the ID/EX register (insert bubble).
- hazardDetected  out  1  equals StallD.
- muldivTimeout  out  1  sticky error flag.
- stallCycles  out  CNT_W  saturating count of cycles with StallF=1.

Behaviour:
- Register 0 never matches. Every comparison is gated with reg != 0.
- ForwardAE: 10 if RsE==WriteRegM && RegWriteM; else 01 if RsE==WriteRegW && RegWriteW; else 00. M takes priority over W. ForwardBE is identical using RtE.
- ForwardAD = (RsD==WriteRegM) && RegWriteM. ForwardBD is the same using RtD.
- lwstall = MemtoRegE && (WriteRegE==RsD || WriteRegE==RtD).
- branchstall = BranchD && ((RegWriteE && WriteRegE matches RsD or RtD) || (MemtoRegM && WriteRegM matches RsD or RtD)).
- FSM states are RUN and MDWAIT. The state register, wait counter (width clog2(MULDIV_MAX+1)), muldivTimeout and stallCycles are the only sequential elements.
- In RUN:
  - StallF = StallD = lwstall | branchstall.
  - FlushE = lwstall | branchstall.
  - StallE = 0.
  - muldivStartE && !muldivDone → MDWAIT next cycle; counter cleared.
  - Start and done in the same cycle → stay in RUN.
  - muldivStartE has priority over lwstall/branchstall: when set, StallF=StallD=StallE=1 and FlushE=0 in that cycle.
- In MDWAIT:
  - StallF=StallD=StallE=1, FlushE=0.
  - Forward selects are still computed normally.
  - Counter increments each cycle.
  - muldivDone → RUN next cycle. Stalls drop in the cycle after done is seen.
  - Counter reaches MULDIV_MAX-1 without done → set muldivTimeout, go to RUN.
  - muldivDone arriving in the same cycle as the timeout counts as done; muldivTimeout is not set.
- Stall, flush and forward outputs are combinational from inputs and state: zero-latency, same cycle.
- stallCycles increments on every clock edge where StallF=1 and holds at all-ones.
- Reset (synchronous, priority over everything):
  - Next state RUN, counter 0, muldivTimeout 0, stallCycles 0.
  - In any cycle with reset high: StallF=StallD=StallE=0 and FlushE=1; forward selects 00.
  - Reset during MDWAIT abandons the wait with no timeout flag.
- muldivDone while in RUN with no start is ignored.

Decomposition:
- Shared package core_pkg holds:
  - fwd_sel_t encoding constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10).
  - the state enum (ST_RUN, ST_MDWAIT).
  - REG_ZERO = 5'd0.
- One sub-module, hazard_match, a combinational comparator: (src, dst, we) → match, with non-zero gating. It is instantiated for every comparison.
- FSM, counters and output muxing stay in hazard_ctrl.

Test Plan:
- Forwarding. RsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 → ForwardAE=10. Then drop RegWriteM → ForwardAE=01. Set RsE=0 with all matches → 00.
- Load-use. MemtoRegE=1, WriteRegE=5, RtD=5 → StallF=StallD=FlushE=hazardDetected=1 for one cycle; stallCycles becomes 1 on the next edge. With WriteRegE=0 → no stall.
- Branch. BranchD=1, RsD=7, RegWriteE=1, WriteRegE=7 → stall+flush. Next cycle with the instruction in M, RegWriteM=1, WriteRegM=7, MemtoRegM=0 → no stall, ForwardAD=1.
- Mul/div. Pulse muldivStartE, then assert muldivDone 4 cycles later → StallE=1 for 5 cycles total, FlushE=0 throughout, stallCycles +5, state returns to RUN.
- Timeout. MULDIV_MAX=8, start with muldivDone never asserted → stalls for 8 cycles, muldivTimeout=1 and sticky. Reset clears it to 0.
- Reset mid-wait. Assert reset in cycle 3 of MDWAIT → that cycle shows StallF=0 and FlushE=1. Next cycle is RUN with stallCycles=0 and muldivTimeout=0.
